demux6_collect: RTL
===================

Name: demux6_collect

Overview:
- Receive-side counterpart to the 6-way mux in the schematic component library.
- Accepts a time-multiplexed stream of words on one input and steers each word into one of six registered outputs o0..o5, using an explicit slot select or an internal slot counter.
- Once all six slots are filled, presents the complete frame with a valid/ready handshake, then starts collecting the next frame.
- Placed in schematics wherever a mux6-driven shared bus must be fanned back out.

Parameters:
- WIREWIDTH, 1, data width minus one; all data ports are [WIREWIDTH:0], matching the library's mux convention.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- auto  input  1  1: slot from internal counter; 0: slot from s.
- s  input  3  explicit slot select; values 6 and 7 map to slot 5, mirroring the mux default.
- din  input  WIREWIDTH+1  incoming word.
- in_valid  input  1  din/s valid this cycle.
- in_ready  output  1  block accepts a word this cycle.
- o0..o5  output  WIREWIDTH+1 each  registered slot outputs.
- frame_valid  output  1  all six slots hold a complete frame.
- out_ready  input  1  consumer takes the frame.
- slot_cnt  output  3  internal slot counter, 0..5.

Behaviour:
- Reset (rst=1 at an edge):
  - o0..o5=0, frame_valid=0, slot_cnt=0, fill mask=6'b0, state=FILL.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after reset.
- Accept condition: in_valid && in_ready at a rising edge.
- Slot select: slot = auto ? slot_cnt : (s>5 ? 5 : s).
- On accept:
  - o[slot] <= din; mask[slot] <= 1.
  - slot_cnt <= (slot==5) ? 0 : slot+1, in both modes.
- Write latency: a word accepted at edge k is visible on o[slot] after edge k.
- Duplicate writes: a write to an already-filled slot overwrites its data; the mask is unchanged. Both modes may be mixed within one frame.
- State FILL:
  - in_ready=1.
  - When an accept makes mask==6'b111111: frame_valid<=1, mask<=0, slot_cnt<=0, state<=FULL.
  - frame_valid rises after the same edge as the final write.
- State FULL:
  - in_ready=0; o0..o5 and frame_valid are held stable.
  - out_ready=1 at an edge: frame_valid<=0, state<=FILL; in_ready returns to 1 in the next cycle.
  - out_ready while in FILL is ignored.
- in_valid with in_ready=0: the word is not accepted. The source must hold din/s until accepted.
- Reset mid-frame discards partial data (outputs cleared to 0).
- rst has priority over all other events in the same cycle.

Optional Feature:
- Macro: DEMUX6_COLLECT_SHADOW_EN.
- Without the macro: behaviour exactly as above (single buffer, in_ready=0 in FULL).
- With the macro: writes go to six internal staging registers instead of o0..o5.
  - On frame completion, staging is copied to o0..o5 at the same edge that frame_valid rises.
  - in_ready stays 1 in FULL, so the next frame fills staging while the outputs are held.
  - If staging completes while still FULL and out_ready=0: in_ready drops to 0 until out_ready.
  - If staging completes in the same cycle that out_ready=1 in FULL: the copy happens and frame_valid stays 1.
  - Reset clears the staging registers to 0.

Test Plan (WIREWIDTH=7):
- Reset, auto=1, feed 8'h11,22,33,44,55,66 on consecutive cycles -> o0..o5=11..66; frame_valid=1 after the 6th edge; slot_cnt=0; in_ready=0.
- Continuing from the full frame, hold out_ready=0 for 5 cycles with in_valid=1 -> outputs unchanged, no accept. Then out_ready=1 -> frame_valid=0 next cycle; in_ready=1.
- auto=0, write s=7 din=8'hA5, then s=0..4 -> o5=A5, frame completes on the 6th write. Rewrite s=2 din=8'hFF before completing -> o2=FF, still needs 6 distinct slots.
- Mid-frame, after 3 writes assert rst for 1 cycle -> all outputs 0, mask and slot_cnt 0; the next 6 writes are required to complete a frame.
- Mixed mode: auto=0 write s=3, then auto=1 -> next auto write lands in slot 4 (slot_cnt=4), then 5, 0, 1, 2 completes the frame.
- DEFINE DEMUX6_COLLECT_SHADOW_EN: fill frame A, keep out_ready=0, send frame B -> in_ready stays 1 for 6 words then 0; o holds A. out_ready=1 -> o shows B, frame_valid stays 1.

Source files
------------

// File: rtl/demux6_collect.sv
// demux6_collect: fans a time-multiplexed word stream back out into six
// registered slots o0..o5 and presents each complete frame with a
// frame_valid / out_ready handshake.
// Optional feature macro: DEMUX6_COLLECT_SHADOW_EN
//   When defined, incoming words are gathered in a staging buffer so the
//   next frame can be collected while the current one is still presented.
module demux6_collect #(
  parameter int WIREWIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               auto,
  input  logic [2:0]         s,
  input  logic [WIREWIDTH:0] din,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIREWIDTH:0] o0,
  output logic [WIREWIDTH:0] o1,
  output logic [WIREWIDTH:0] o2,
  output logic [WIREWIDTH:0] o3,
  output logic [WIREWIDTH:0] o4,
  output logic [WIREWIDTH:0] o5,
  output logic               frame_valid,
  input  logic               out_ready,
  output logic [2:0]         slot_cnt
);

  // FILL: collecting, no frame presented. FULL: frame presented.
  // STALL (staging build only): frame presented and staging also complete.
  typedef enum logic [1:0] {FILL, FULL, STALL} state_t;

  state_t             state_q, state_d;
  logic [WIREWIDTH:0] outData_q [6];
  logic [WIREWIDTH:0] outData_d [6];
  logic [5:0]         mask_q, mask_d;
  logic [2:0]         slotCnt_q, slotCnt_d;
  logic               frameValid_q, frameValid_d;

  logic               accept;
  logic               complete;
  logic [2:0]         slotSel;
  logic [2:0]         slotNext;
  logic [5:0]         maskWr;

`ifdef DEMUX6_COLLECT_SHADOW_EN
  logic [WIREWIDTH:0] stage_q [6];
  logic [WIREWIDTH:0] stage_d [6];

  // Staging keeps accepting while a frame is presented; only a second
  // complete frame waiting behind the presented one blocks the input.
  assign in_ready = !rst && (state_q != STALL);
`else
  // Single buffer: the input is blocked while a frame is presented.
  assign in_ready = !rst && (state_q == FILL);
`endif

  assign accept = in_valid && in_ready;

  // Resolve the target slot and the bookkeeping a write would produce.
  always_comb begin
    slotSel  = auto ? slotCnt_q : ((s > 3'd5) ? 3'd5 : s);
    maskWr   = mask_q | (6'b000001 << slotSel);
    complete = accept && (maskWr == 6'b111111);
    slotNext = (slotSel == 3'd5) ? 3'd0 : (slotSel + 3'd1);
  end

`ifdef DEMUX6_COLLECT_SHADOW_EN
  // Next-state logic: writes land in staging, and staging is copied to the
  // outputs whenever the output side is free to take a new frame.
  always_comb begin
    state_d      = state_q;
    outData_d    = outData_q;
    stage_d      = stage_q;
    mask_d       = mask_q;
    slotCnt_d    = slotCnt_q;
    frameValid_d = frameValid_q;
    if (accept) begin
      for (int i = 0; i < 6; i++) begin
        if (slotSel == 3'(i)) stage_d[i] = din;
      end
      mask_d    = maskWr;
      slotCnt_d = slotNext;
    end
    if (complete) begin
      mask_d    = 6'b0;
      slotCnt_d = 3'd0;
    end
    case (state_q)
      FILL: begin
        if (complete) begin
          outData_d    = stage_d;
          frameValid_d = 1'b1;
          state_d      = FULL;
        end
      end
      FULL: begin
        if (complete && out_ready) begin
          outData_d = stage_d;
        end else if (complete) begin
          state_d = STALL;
        end else if (out_ready) begin
          frameValid_d = 1'b0;
          state_d      = FILL;
        end
      end
      STALL: begin
        if (out_ready) begin
          outData_d = stage_q;
          state_d   = FULL;
        end
      end
      default: state_d = FILL;
    endcase
  end
`else
  // Next-state logic: writes go straight to the outputs while filling; a
  // presented frame is held until the consumer takes it.
  always_comb begin
    state_d      = state_q;
    outData_d    = outData_q;
    mask_d       = mask_q;
    slotCnt_d    = slotCnt_q;
    frameValid_d = frameValid_q;
    if (accept) begin
      for (int i = 0; i < 6; i++) begin
        if (slotSel == 3'(i)) outData_d[i] = din;
      end
      mask_d    = maskWr;
      slotCnt_d = slotNext;
    end
    if (complete) begin
      frameValid_d = 1'b1;
      mask_d       = 6'b0;
      slotCnt_d    = 3'd0;
      state_d      = FULL;
    end
    if ((state_q == FULL) && out_ready) begin
      frameValid_d = 1'b0;
      state_d      = FILL;
    end
    if (state_q == STALL) begin
      state_d = FILL;
    end
  end
`endif

  // State register with synchronous reset that discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      mask_q       <= 6'b0;
      slotCnt_q    <= 3'd0;
      frameValid_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        outData_q[i] <= '0;
`ifdef DEMUX6_COLLECT_SHADOW_EN
        stage_q[i]   <= '0;
`endif
      end
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      slotCnt_q    <= slotCnt_d;
      frameValid_q <= frameValid_d;
      outData_q    <= outData_d;
`ifdef DEMUX6_COLLECT_SHADOW_EN
      stage_q      <= stage_d;
`endif
    end
  end

  assign o0          = outData_q[0];
  assign o1          = outData_q[1];
  assign o2          = outData_q[2];
  assign o3          = outData_q[3];
  assign o4          = outData_q[4];
  assign o5          = outData_q[5];
  assign frame_valid = frameValid_q;
  assign slot_cnt    = slotCnt_q;

endmodule
